// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 set-2 keyboard front end: deserialise frames, decode make/break/shift to ASCII, queue in a small FIFO.
// Latency: char is pushed 1 cycle after the byte completes; KB_status rises the cycle after that.
// Backpressure: none toward the keyboard; a char arriving while the FIFO is full (and not popped) is dropped.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       SYS_CLK,
    input  logic       reset,
    input  logic       ps2_in,
    input  logic       ps2_clk,
    input  logic       KB_read_en,
    input  logic       KB_clear,
    output logic       KB_status,
    output logic [6:0] KB_data,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic            r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    rx_state_t       r_state, w_next_state;
    logic [7:0]      r_rx_byte;
    logic [2:0]      r_bit_cnt;
    logic            r_perr, r_byte_vld, r_frame_err;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_shift_on, r_brk, r_ext, r_push;
    logic [6:0]      r_push_char;
    logic [6:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic            w_fall, w_tmo, w_empty, w_full, w_push, w_pop, w_is_shift_code;
    logic [7:0]      w_map;
    logic [6:0]      w_char;

    // Set-2 make code to lowercase ASCII; bit 7 flags a mapped key.
    function automatic logic [7:0] f_lookup(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            8'h1C: m = {1'b1, 7'h61}; 8'h32: m = {1'b1, 7'h62}; 8'h21: m = {1'b1, 7'h63};
            8'h23: m = {1'b1, 7'h64}; 8'h24: m = {1'b1, 7'h65}; 8'h2B: m = {1'b1, 7'h66};
            8'h34: m = {1'b1, 7'h67}; 8'h33: m = {1'b1, 7'h68}; 8'h43: m = {1'b1, 7'h69};
            8'h3B: m = {1'b1, 7'h6A}; 8'h42: m = {1'b1, 7'h6B}; 8'h4B: m = {1'b1, 7'h6C};
            8'h3A: m = {1'b1, 7'h6D}; 8'h31: m = {1'b1, 7'h6E}; 8'h44: m = {1'b1, 7'h6F};
            8'h4D: m = {1'b1, 7'h70}; 8'h15: m = {1'b1, 7'h71}; 8'h2D: m = {1'b1, 7'h72};
            8'h1B: m = {1'b1, 7'h73}; 8'h2C: m = {1'b1, 7'h74}; 8'h3C: m = {1'b1, 7'h75};
            8'h2A: m = {1'b1, 7'h76}; 8'h1D: m = {1'b1, 7'h77}; 8'h22: m = {1'b1, 7'h78};
            8'h35: m = {1'b1, 7'h79}; 8'h1A: m = {1'b1, 7'h7A};
            8'h45: m = {1'b1, 7'h30}; 8'h16: m = {1'b1, 7'h31}; 8'h1E: m = {1'b1, 7'h32};
            8'h26: m = {1'b1, 7'h33}; 8'h25: m = {1'b1, 7'h34}; 8'h2E: m = {1'b1, 7'h35};
            8'h36: m = {1'b1, 7'h36}; 8'h3D: m = {1'b1, 7'h37}; 8'h3E: m = {1'b1, 7'h38};
            8'h46: m = {1'b1, 7'h39};
            8'h29: m = {1'b1, 7'h20}; 8'h5A: m = {1'b1, 7'h0D}; 8'h66: m = {1'b1, 7'h08};
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Two-flop synchronisers for the asynchronous PS/2 lines, preset to the idle-high level.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_clk_prev <= 1'b1;
            r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;  r_clk_s2 <= r_clk_s1; r_clk_prev <= r_clk_s2;
            r_dat_s1 <= ps2_in;   r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_tmo  = (r_state != S_IDLE) && !w_fall && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // RX state register.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // RX next state: advance one field per ps2_clk fall; a stalled frame falls back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !r_dat_s2) w_next_state = S_DATA;
            S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_next_state = S_PARITY;
            S_PARITY: if (w_fall) w_next_state = S_STOP;
            S_STOP:   if (w_fall) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        if (w_tmo) w_next_state = S_IDLE;
    end

    // RX datapath: shift in bits LSB first, check odd parity and stop bit, run the stall timer.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_rx_byte <= 8'h00; r_bit_cnt <= 3'd0; r_perr <= 1'b0;
            r_byte_vld <= 1'b0; r_frame_err <= 1'b0; r_tmo_cnt <= '0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall || r_state == S_IDLE) r_tmo_cnt <= '0;
            else                             r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_tmo) begin
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE:   if (!r_dat_s2) begin r_bit_cnt <= 3'd0; r_perr <= 1'b0; end
                    S_DATA:   begin r_rx_byte <= {r_dat_s2, r_rx_byte[7:1]}; r_bit_cnt <= r_bit_cnt + 3'd1; end
                    S_PARITY: r_perr <= ~(^{r_rx_byte, r_dat_s2});
                    S_STOP:   if (r_dat_s2 && !r_perr) r_byte_vld <= 1'b1;
                              else                     r_frame_err <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign frame_err = r_frame_err;

    // Shift key folds lowercase letters to uppercase; digits and controls pass through.
    always_comb begin
        w_map           = f_lookup(r_rx_byte);
        w_char          = w_map[6:0];
        w_is_shift_code = (r_rx_byte == 8'h12) || (r_rx_byte == 8'h59);
        if (r_shift_on && w_map[6:0] >= 7'h61 && w_map[6:0] <= 7'h7A) w_char = w_map[6:0] - 7'h20;
    end

    // Scan-code decoder: track E0/F0 prefixes and shift state, stage one char for the FIFO.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_shift_on <= 1'b0; r_brk <= 1'b0; r_ext <= 1'b0;
            r_push <= 1'b0; r_push_char <= 7'h00;
        end else begin
            r_push <= 1'b0;
            if (KB_clear) begin
                r_shift_on <= 1'b0; r_brk <= 1'b0; r_ext <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_rx_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_rx_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    if (r_brk) begin
                        if (w_is_shift_code) r_shift_on <= 1'b0;
                    end else if (!r_ext) begin
                        if (w_is_shift_code) r_shift_on <= 1'b1;
                        else if (w_map[7]) begin r_push <= 1'b1; r_push_char <= w_char; end
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = KB_read_en & ~w_empty;
    assign w_push  = r_push & (~w_full | w_pop);

    // FIFO pointers; a clear overrides any push or pop in the same cycle.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0; r_rd_ptr <= '0;
        end else if (KB_clear) begin
            r_wr_ptr <= '0; r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge SYS_CLK) begin
        if (w_push && !KB_clear) r_mem[r_wr_ptr[AW-1:0]] <= r_push_char;
    end

    assign KB_status = ~w_empty;
    assign KB_data   = w_empty ? 7'h00 : r_mem[r_rd_ptr[AW-1:0]];
endmodule
